// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally (fall-through).
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        full, empty, do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch front end: PC, credit-limited imem requests, in-order response buffering
// toward decode, and redirect handling that discards stale in-flight responses.
module instr_fetch_stage
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic [31:0]      pcq_head;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_push_data;
    logic             credit, req_fire, resp_live, resp_drop, pop;

    // Outstanding requests plus buffered entries never exceed the FIFO depth,
    // so a live response always finds room.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit    = (state_q == RUN) && !redirect_valid &&
                       (in_use < (CNT_W + 1)'(FIFO_DEPTH));
    assign req_fire  = credit && imem_req_ready;
    assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_live = imem_resp_valid && (drop_cnt_q == '0) && (outstanding != '0);
    assign pop       = if_valid && if_ready;

    assign imem_req_valid = credit;
    assign imem_req_addr  = pc_q;

    assign fifo_push_data = '{pc: pcq_head, instr: imem_resp_data};

    assign if_valid    = (fifo_count != '0);
    assign if_instr    = if_valid ? fifo_head.instr : NOP_INSTR;
    assign if_pc       = if_valid ? fifo_head.pc : '0;
    assign if_pc_plus4 = if_valid ? fifo_head.pc + INSTR_BYTES : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_live),
        .flush     (redirect_valid),
        .head      (pcq_head),
        .count     (outstanding)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_live),
        .push_data (fifo_push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        if (req_fire) begin
            pc_d = pc_q + INSTR_BYTES;
        end
        // Everything still in flight after this edge becomes stale; the pc
        // queue is flushed so outstanding restarts from zero.
        if (redirect_valid) begin
            pc_d       = align_pc(redirect_pc);
            drop_cnt_d = drop_cnt_d + outstanding + CNT_W'(req_fire) - CNT_W'(resp_live);
        end
        state_d = (drop_cnt_d == '0) ? RUN : DRAIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((outstanding != '0) || (drop_cnt_q != '0)));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a program-order fetch model.
module tb_instr_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        w_req_valid;
    logic        w_req_ready = 1'b1;
    logic [31:0] w_req_addr;
    logic        w_resp_valid = 1'b0;
    logic [31:0] w_resp_data = 32'h0;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_if_valid;
    logic        w_if_ready = 1'b1;
    logic [31:0] w_if_instr, w_if_pc, w_if_pc_plus4;

    always #5 clk = ~clk;

    instr_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    instr_fetch_stage #(.RESET_PC(RPC_W), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .if_valid(w_if_valid), .if_ready(w_if_ready), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'hAC03_0040;
            32'h4: return 32'h8C24_0002;
            32'h8: return 32'h00A6_3820;
            default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Memory / decode environment knobs (percent chance per cycle)
    int ready_pct = 100, resp_pct = 100, dec_pct = 100;

    // Reference model: program-order fetch and decode streams
    logic [31:0] memq[$];
    logic [31:0] exp_fetch_pc = RPC, exp_dec_pc = RPC;
    int          stale = 0, buffered = 0, issued = 0, popped = 0;
    logic        rst_prev = 1'b0;

    // Directed-test captures
    int          cyc = 0, fires = 0, t_req = -1, t_val = -1;
    logic        lat_arm = 1'b0, req_arm = 1'b0, pop_arm = 1'b0;
    logic [31:0] req_cap = 32'hDEAD_BEEF, pop_cap = 32'hDEAD_BEEF;
    logic [31:0] pop_log[$];
    logic [31:0] w_addr_log[$], w_pc_log[$], w_p4_log[$];
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_addr = 32'h0;

    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if_ready        = 1'b0;
        forever begin
            @(posedge clk); #2;
            imem_req_ready = (int'($urandom_range(99)) < ready_pct);
            if_ready       = (int'($urandom_range(99)) < dec_pct);
            if (memq.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(memq[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            w_resp_valid = w_pend;
            w_resp_data  = mem_word(w_pend_addr);
        end
    end

    always @(negedge clk) begin : mon
        logic        boot;
        logic        want_req;
        cyc++;
        if (rst_prev) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_if_valid", if_valid, 0);
            chk("rst_req_addr", imem_req_addr, RPC);
            chk("rst_if_instr", if_instr, 0);
            chk("rst_if_pc", if_pc, 0);
            chk("rst_if_pc4", if_pc_plus4, 0);
        end
        if (!rst) begin
            boot = rst_prev;
            chk("if_valid", if_valid, buffered != 0);
            if (if_valid) begin
                chk("if_pc", if_pc, exp_dec_pc);
                chk("if_instr", if_instr, mem_word(exp_dec_pc));
                chk("if_pc_plus4", if_pc_plus4, exp_dec_pc + 32'd4);
            end
            want_req = !boot && !redirect_valid && stale == 0 && (issued - popped) < DEPTH;
            chk("req_valid", imem_req_valid, want_req);
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch_pc);

            if (imem_req_valid && imem_req_ready) begin
                memq.push_back(exp_fetch_pc);
                exp_fetch_pc += 32'd4;
                issued++;
                fires++;
                if (lat_arm && t_req < 0) t_req = cyc;
                if (req_arm) begin req_cap = imem_req_addr; req_arm = 1'b0; end
            end
            if (if_valid) begin
                if (t_req >= 0 && t_val < 0) t_val = cyc;
                if (pop_arm) begin pop_cap = if_pc; pop_arm = 1'b0; end
            end
            if (imem_resp_valid && memq.size() > 0) begin
                void'(memq.pop_front());
                if (stale > 0) stale--;
                else buffered++;
            end
            if (if_valid && if_ready) begin
                pop_log.push_back(if_instr);
                exp_dec_pc += 32'd4;
                buffered--;
                popped++;
            end
            if (redirect_valid) begin
                exp_fetch_pc = {redirect_pc[31:2], 2'b00};
                exp_dec_pc   = {redirect_pc[31:2], 2'b00};
                stale        = memq.size();
                buffered     = 0;
                issued       = 0;
                popped       = 0;
            end

            if (w_req_valid) w_addr_log.push_back(w_req_addr);
            if (w_if_valid) begin
                w_pc_log.push_back(w_if_pc);
                w_p4_log.push_back(w_if_pc_plus4);
            end
            w_pend      = w_req_valid && w_req_ready;
            w_pend_addr = w_req_addr;
        end else begin
            memq.delete();
            exp_fetch_pc = RPC;
            exp_dec_pc   = RPC;
            stale = 0; buffered = 0; issued = 0; popped = 0;
            w_pend = 1'b0;
        end
        rst_prev = rst;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // A: straight-line fetch, latency and first words; wrap instance alongside
        step(3);
        t_req = -1; t_val = -1; lat_arm = 1'b1;
        pop_log.delete(); w_addr_log.delete(); w_pc_log.delete(); w_p4_log.delete();
        rst = 1'b0;
        step(12);
        lat_arm = 1'b0;
        chk("first_lat", t_val - t_req, 2);
        chk("pop_log_n", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            chk("word0", pop_log[0], 32'hAC03_0040);
            chk("word1", pop_log[1], 32'h8C24_0002);
            chk("word2", pop_log[2], 32'h00A6_3820);
        end
        chk("wrap_n", (w_addr_log.size() >= 2) && (w_pc_log.size() >= 2), 1);
        if (w_addr_log.size() >= 2 && w_pc_log.size() >= 2) begin
            chk("wrap_addr0", w_addr_log[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", w_addr_log[1], 32'h0000_0000);
            chk("wrap_pc0", w_pc_log[0], 32'hFFFF_FFFC);
            chk("wrap_pc4_0", w_p4_log[0], 32'h0000_0000);
            chk("wrap_pc1", w_pc_log[1], 32'h0000_0000);
        end

        // B: decode stalled from reset -> credit limit, stable head, no loss
        rst = 1'b1; dec_pct = 0;
        step(2);
        fires = 0; pop_log.delete();
        rst = 1'b0;
        step(12);
        chk("stall_fires", fires <= DEPTH, 1);
        chk("stall_valid", if_valid, 1);
        chk("stall_instr", if_instr, 32'hAC03_0040);
        dec_pct = 100;
        step(10);
        chk("stall_log_n", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            chk("stall_w0", pop_log[0], 32'hAC03_0040);
            chk("stall_w1", pop_log[1], 32'h8C24_0002);
            chk("stall_w2", pop_log[2], 32'h00A6_3820);
        end

        // C: redirect to 0x8 with two responses in flight
        resp_pct = 0;
        step(6);
        chk("inflight", memq.size(), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
        step();
        redirect_valid = 1'b0; resp_pct = 100;
        chk("drain_noreq", imem_req_valid, 0);
        req_cap = 32'hDEAD_BEEF; pop_cap = 32'hDEAD_BEEF;
        req_arm = 1'b1; pop_arm = 1'b1;
        step(10);
        chk("redir_addr", req_cap, 32'h0000_0008);
        chk("redir_if_pc", pop_cap, 32'h0000_0008);

        // D: misaligned redirect target is word-aligned
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
        step();
        redirect_valid = 1'b0;
        req_cap = 32'hDEAD_BEEF; pop_cap = 32'hDEAD_BEEF;
        req_arm = 1'b1; pop_arm = 1'b1;
        step(10);
        chk("align_addr", req_cap, 32'h0000_0010);
        chk("align_if_pc", pop_cap, 32'h0000_0010);

        // E: random traffic with random redirects
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ready_pct = int'($urandom_range(30, 100));
                resp_pct  = int'($urandom_range(20, 100));
                dec_pct   = int'($urandom_range(10, 100));
            end
            if (!redirect_valid && int'($urandom_range(99)) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                       : $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        ready_pct = 100; resp_pct = 100; dec_pct = 100;
        step(5);

        // F: reset while draining
        resp_pct = 0;
        step(6);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; resp_pct = 100;
        chk("rst_drain_valid", if_valid, 0);
        chk("rst_drain_req", imem_req_valid, 0);
        req_cap = 32'hDEAD_BEEF; req_arm = 1'b1;
        step(6);
        chk("post_rst_addr", req_cap, RPC);
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
